// File: rtl/pipe_pkg.sv
// Shared definitions for the core's inter-stage pipeline registers.
// Provides the skid FSM state encoding, the default bubble payload and
// the payload widths of each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    // Occupancy of a stage register: nothing held, main entry held,
    // or main entry plus one parked entry in the skid slot.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_t;

    // Default payload width and the all-zero word that decodes as a NOP.
    localparam int DEFAULT_DATA_W = 200;
    localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_NOP_PAYLOAD = '0;

    // Packed payload widths carried across each stage boundary.
    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 200;
    localparam int EX_MEM_W = 144;
    localparam int MEM_WB_W = 104;

    // True when a state holds an entry that can be presented downstream.
    function automatic logic state_has_main(input pipe_state_t s);
        return (s == PIPE_BUSY) || (s == PIPE_FULL);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid slot and occupancy FSM for pipe_stage_reg when the skid buffer
// (PIPE_SKID_EN) is built in. The main payload register lives in the top
// level; this block tells it when to load and from where, and keeps the
// second (skid) entry so that in_ready no longer depends on out_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              main_valid,
    output logic              main_load,
    output logic              main_from_skid,
    output logic              main_clear,
    output logic [DATA_W-1:0] skid_data
);

    pipe_state_t state;
    logic        skid_valid;
    logic        in_xfer;
    logic        out_xfer;

    // Occupancy flags decode straight from the registered state.
    assign main_valid = state_has_main(state);
    assign skid_valid = (state == PIPE_FULL);

    // Upstream may push whenever the skid slot is free; the stall, flush
    // and reset gates keep anything from being accepted in those cycles.
    assign in_ready = ~skid_valid & ~hold & ~flush & ~rst;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & ~hold & out_ready;

    // Steer the main register: fresh load, refill from skid, or empty out.
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        case (state)
            PIPE_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                end
            end
            PIPE_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    main_clear = 1'b1;
                end
            end
            PIPE_FULL: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                main_clear = 1'b1;
            end
        endcase
    end

    // Occupancy FSM and skid slot; flush drops both entries like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= PIPE_EMPTY;
            skid_data <= '0;
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (in_xfer) begin
                        state <= PIPE_BUSY;
                    end
                end
                PIPE_BUSY: begin
                    if (in_xfer && !out_xfer) begin
                        state     <= PIPE_FULL;
                        skid_data <= in_data;
                    end else if (out_xfer && !in_xfer) begin
                        state <= PIPE_EMPTY;
                    end
                end
                PIPE_FULL: begin
                    if (out_xfer) begin
                        state <= PIPE_BUSY;
                    end
                end
                default: begin
                    state <= PIPE_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// hold (stall), flush (bubble insert) and a saturating stall counter.
// Build option: define PIPE_SKID_EN to add a 2-entry skid buffer that
// registers in_ready; otherwise a single register with a combinational
// out_ready -> in_ready through-path is built.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 200,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stalled;

    // A held stage shows a bubble downstream but keeps its payload visible.
    assign out_valid = valid_q & ~hold;
    assign out_data  = data_q;
    assign stall_cnt = cnt_q;

`ifdef PIPE_SKID_EN

    logic              main_load;
    logic              main_from_skid;
    logic              main_clear;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .hold          (hold),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_ready     (out_ready),
        .in_ready      (in_ready),
        .main_valid    (valid_q),
        .main_load     (main_load),
        .main_from_skid(main_from_skid),
        .main_clear    (main_clear),
        .skid_data     (skid_data)
    );

    // Main payload register, loaded from upstream or from the skid slot
    // and returned to the bubble payload whenever the stage empties.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            data_q <= NOP_PAYLOAD;
        end else if (main_load) begin
            data_q <= main_from_skid ? skid_data : in_data;
        end else if (main_clear) begin
            data_q <= NOP_PAYLOAD;
        end
    end

`else

    logic in_xfer;
    logic out_xfer;

    // Single entry: room exists when empty or when the entry leaves now.
    assign in_ready = ~rst & ~flush & ~hold & (~valid_q | out_ready);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Single-entry register; a concurrent push and pop replace the entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
            data_q  <= NOP_PAYLOAD;
        end else if (in_xfer) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
            data_q  <= NOP_PAYLOAD;
        end
    end

`endif

    // A cycle counts as stalled when a held entry is refused downstream
    // or the hazard unit freezes the stage.
    assign stalled = (valid_q & ~out_ready) | hold;

    // Saturating stall counter; only reset clears it, flush leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
